// File: rtl/accum_drain_pkg.sv
// Shared types, widths and the signed-to-sign/magnitude conversion for accum_drain.
package accum_drain_pkg;

  localparam int ACC_W  = 32;
  localparam int MAG_W  = 31;
  localparam int KLEN_W = 8;

  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {MAG_W{1'b0}}};

  typedef enum logic [1:0] {
    ACCUM,
    CAPTURE,
    CLEAR
  } stateT;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } resultT;

  // The most negative value wraps to magnitude 0 here; saturation is applied by the caller.
  function automatic resultT convert(input logic [ACC_W-1:0] acc);
    resultT           r;
    logic [ACC_W-1:0] neg;
    neg    = -acc;
    r.sign = acc[ACC_W-1];
    r.mag  = acc[ACC_W-1] ? neg[MAG_W-1:0] : acc[MAG_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/accum_drain_fifo.sv
// First-word-fall-through result FIFO: the head entry is visible whenever the FIFO is not empty.
module accum_drain_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           pushData,
  output logic [WIDTH-1:0]           headData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign doPop    = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign doPush   = push && (!full || doPop);
  assign headData = mem[rdPtr];

  // NOTE: storage has no reset; validity comes from count, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/accum_drain.sv
// Closes convolution windows on an external accumulator, queues sign/magnitude results and clears the accumulator.
// Optional macro ACCUM_DRAIN_SAT_EN saturates the most negative sum and raises a sticky Overflow flag.
module accum_drain
  import accum_drain_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  KernelLen,
  input  logic        TapValid,
  output logic        TapReady,
  input  logic [31:0] AccumIn,
  output logic        AccumReset,
  output logic [30:0] OutMag,
  output logic        OutSign,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [3:0]  FifoCount,
  output logic        Overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  stateT             state;
  logic [KLEN_W-1:0] tapCount;
  logic [KLEN_W-1:0] klenLatched;
  logic [KLEN_W-1:0] windowLen;
  logic              tapAccept;
  logic              lastTap;
  logic              capturePush;
  logic              fifoPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  fifoCnt;
  resultT            captured;
  resultT            head;

  // The first tap of a window reads KernelLen directly; later taps use the latched copy.
  assign windowLen   = (tapCount != '0)   ? klenLatched :
                       (KernelLen == '0)  ? KLEN_W'(1)  : KernelLen;
  assign tapAccept   = TapValid && TapReady;
  assign lastTap     = ((tapCount + KLEN_W'(1)) == windowLen);
  assign fifoPop     = OutValid && OutReady;
  assign capturePush = (state == CAPTURE) && (!fifoFull || fifoPop);

  always_comb begin
    captured = convert(AccumIn);
`ifdef ACCUM_DRAIN_SAT_EN
    if (AccumIn == ACC_MIN) captured.mag = '1;
`endif
  end

  // TapReady and AccumReset are registered alongside state so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLEAR;
      AccumReset  <= 1'b1;
      TapReady    <= 1'b0;
      tapCount    <= '0;
      klenLatched <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (tapAccept) begin
            if (tapCount == '0) klenLatched <= windowLen;
            if (lastTap) begin
              tapCount <= '0;
              state    <= CAPTURE;
              TapReady <= 1'b0;
            end else begin
              tapCount <= tapCount + KLEN_W'(1);
            end
          end
        end
        CAPTURE: begin
          if (capturePush) begin
            state      <= CLEAR;
            AccumReset <= 1'b1;
          end
        end
        CLEAR: begin
          state      <= ACCUM;
          AccumReset <= 1'b0;
          TapReady   <= 1'b1;
        end
        default: begin
          state      <= CLEAR;
          AccumReset <= 1'b1;
          TapReady   <= 1'b0;
        end
      endcase
    end
  end

`ifdef ACCUM_DRAIN_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   Overflow <= 1'b0;
    else if (capturePush && AccumIn == ACC_MIN) Overflow <= 1'b1;
  end
`else
  assign Overflow = 1'b0;
`endif

  accum_drain_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ACC_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (capturePush),
    .pop      (fifoPop),
    .pushData (captured),
    .headData (head),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCnt)
  );

  // Uninitialised storage is hidden behind empty so the outputs read zero when idle.
  assign OutValid  = !fifoEmpty;
  assign OutSign   = fifoEmpty ? 1'b0 : head.sign;
  assign OutMag    = fifoEmpty ? '0   : head.mag;
  assign FifoCount = 4'(fifoCnt);

endmodule

// File: doc/accum_drain.md
ACCUM_DRAIN -- requirements
Module: accum_drain

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, result FIFO entries; legal 2..8, power of two.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port KernelLen  input  8  taps per convolution window; 0 treated as 1.
REQ-005 Port TapValid  input  1  source presents a product to the accumulator this cycle.
REQ-006 Port TapReady  output  1  block accepts a tap this cycle.
REQ-007 Port AccumIn  input  32  accumulator running sum, two's complement.
REQ-008 Port AccumReset  output  1  registered clear to accumulator.
REQ-009 Port OutMag  output  31  result magnitude.
REQ-010 Port OutSign  output  1  result sign, 1 = negative.
REQ-011 Port OutValid / OutReady  output / input  1 / 1  result handshake.
REQ-012 Port FifoCount  output  4  FIFO occupancy.
REQ-013 Port Overflow  output  1  sticky saturation flag.

Function
REQ-014 Tap accepted on rising edge with TapValid & TapReady; TapReady = 1 only in state ACCUM.
REQ-015 System contract: source zeroes accumulator addend when tap not accepted, so AccumIn stays constant outside ACCUM.
REQ-016 KernelLen latched on first accepted tap of a window; changes mid-window ignored.
REQ-017 8-bit tap counter increments per accepted tap; accepting tap number KernelLen clears counter and moves ACCUM -> CAPTURE.
REQ-018 CAPTURE: at next rising edge, if FIFO has space (count < FIFO_DEPTH, or a pop occurs same edge), push converted AccumIn and move to CLEAR; else remain in CAPTURE.
REQ-019 CLEAR lasts exactly one cycle, AccumReset = 1 for that whole cycle (covers the accumulator's falling-edge update), then -> ACCUM.
REQ-020 AccumReset = 0 in ACCUM and CAPTURE.
REQ-021 Conversion: OutSign = AccumIn[31]; OutMag = AccumIn[30:0] if non-negative, else low 31 bits of two's-complement negation.
REQ-022 FIFO first-word-fall-through; OutValid = (FifoCount != 0); pop on OutValid & OutReady; OutMag/OutSign stable while OutValid & !OutReady.
REQ-023 Window throughput: KernelLen accepted taps + 2 bubble cycles minimum.

Reset
REQ-024 rst asserted: state = CLEAR, AccumReset = 1, tap counter = 0, FIFO empty, FifoCount = 0, OutValid = 0, OutMag = 0, OutSign = 0, Overflow = 0, TapReady = 0.
REQ-025 First rising edge after rst deasserts: CLEAR -> ACCUM, AccumReset = 0.
REQ-026 rst mid-window or mid-CAPTURE discards partial window and FIFO contents.

Configuration
REQ-027 Macro ACCUM_DRAIN_SAT_EN defined: AccumIn = 0x80000000 yields OutMag = 0x7FFFFFFF, OutSign = 1, Overflow set and held until rst.
REQ-028 Macro undefined: same input yields OutMag = 0, OutSign = 1; Overflow tied 0.

Structure
REQ-029 Package accum_drain_pkg holds state enum {ACCUM, CAPTURE, CLEAR}, ACC_W = 32, MAG_W = 31, KLEN_W = 8.
REQ-030 Sub-module accum_drain_fifo: FIFO_DEPTH x 32 FWFT FIFO (push, pop, full, empty, count); conversion and FSM stay in accum_drain.

Verification
REQ-031 KernelLen = 3, taps every cycle, AccumIn = 0x0000002A after third tap -> OutValid, OutMag = 42, OutSign = 0, one-cycle AccumReset pulse, TapReady low 2 cycles.
REQ-032 AccumIn = 0xFFFFFFF9 at capture -> OutMag = 7, OutSign = 1.
REQ-033 OutReady = 0, FIFO_DEPTH = 4, five windows of KernelLen = 1 -> FifoCount = 4, fifth window holds in CAPTURE, AccumReset not pulsed, TapReady = 0; OutReady = 1 -> drains in order, fifth pushed.
REQ-034 KernelLen = 0 -> every accepted tap closes a window; KernelLen changed 4 -> 2 after first tap -> window still closes after 4 taps.
REQ-035 AccumIn = 0x80000000 -> with ACCUM_DRAIN_SAT_EN: 0x7FFFFFFF, Overflow = 1; without: OutMag = 0, Overflow = 0.
REQ-036 rst pulse during CAPTURE with FifoCount = 2 -> all outputs at REQ-024 values immediately, AccumReset = 1 until first edge after release.
